// File: rtl/writeback_if.sv
// Writeback stage bus: execute result, decode issue/read requests and the
// values, hazard flags and retired-write count returned to the pipeline.
interface writeback_if #(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned COUNT_WIDTH = 32
);
  logic [WORD_SIZE-1:0]   data_in;
  logic [4:0]             reg_dest_in;
  logic                   write_enable_in;
  logic                   issue_valid;
  logic [4:0]             issue_dest;
  logic [4:0]             read_addr1;
  logic [4:0]             read_addr2;
  logic [WORD_SIZE-1:0]   read_data1;
  logic [WORD_SIZE-1:0]   read_data2;
  logic                   hazard1;
  logic                   hazard2;
  logic [COUNT_WIDTH-1:0] retire_count;

  // Pipeline side: presents results, issues and read requests.
  modport master (
    output data_in, reg_dest_in, write_enable_in, issue_valid, issue_dest,
    output read_addr1, read_addr2,
    input  read_data1, read_data2, hazard1, hazard2, retire_count
  );

  // Writeback stage side.
  modport slave (
    input  data_in, reg_dest_in, write_enable_in, issue_valid, issue_dest,
    input  read_addr1, read_addr2,
    output read_data1, read_data2, hazard1, hazard2, retire_count
  );
endinterface

// File: rtl/writeback.sv
// Writeback stage and 32-entry architectural register file.
// A result is latched on one edge and committed on the next. Two
// combinational read ports report per-register pending hazards from the
// issue scoreboard. Optional macro WB_BYPASS_EN forwards the latched,
// not-yet-committed result to the read ports one cycle early.
module writeback #(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input logic        clock,
  input logic        reset_n,
  writeback_if.slave bus
);

  logic [WORD_SIZE-1:0]   wb_data_q;
  logic [4:0]             wb_rd_q;
  logic                   wb_we_q;
  logic [WORD_SIZE-1:0]   regs_q [32];
  logic [31:0]            pending_q;
  logic [31:0]            pending_d;
  logic [COUNT_WIDTH-1:0] retire_count_q;
  logic                   commit;

  // Writes aimed at x0 are dropped here, so they neither land nor count.
  assign commit = wb_we_q && (wb_rd_q != 5'd0);

  // Stage latch: capture the execute result every edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_we_q   <= 1'b0;
    end else begin
      wb_data_q <= bus.data_in;
      wb_rd_q   <= bus.reg_dest_in;
      wb_we_q   <= bus.write_enable_in;
    end
  end

  // Register file: commit the latched result one edge after capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      regs_q[wb_rd_q] <= wb_data_q;
    end
  end

  // Scoreboard next state: a same-edge issue is younger than the commit,
  // so the set is applied after the clear.
  always_comb begin
    pending_d = pending_q;
    if (commit) begin
      pending_d[wb_rd_q] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_dest != 5'd0)) begin
      pending_d[bus.issue_dest] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Scoreboard and retired-write counter state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q      <= '0;
      retire_count_q <= '0;
    end else begin
      pending_q      <= pending_d;
      retire_count_q <= retire_count_q + COUNT_WIDTH'(commit);
    end
  end

  // Combinational read ports with optional forwarding from the stage latch.
  always_comb begin
    bus.read_data1 = (bus.read_addr1 == 5'd0) ? '0 : regs_q[bus.read_addr1];
    bus.read_data2 = (bus.read_addr2 == 5'd0) ? '0 : regs_q[bus.read_addr2];
    bus.hazard1    = pending_q[bus.read_addr1];
    bus.hazard2    = pending_q[bus.read_addr2];
`ifdef WB_BYPASS_EN
    if (wb_we_q && (wb_rd_q == bus.read_addr1) && (bus.read_addr1 != 5'd0)) begin
      bus.read_data1 = wb_data_q;
      bus.hazard1    = 1'b0;
    end
    if (wb_we_q && (wb_rd_q == bus.read_addr2) && (bus.read_addr2 != 5'd0)) begin
      bus.read_data2 = wb_data_q;
      bus.hazard2    = 1'b0;
    end
`endif
  end

  assign bus.retire_count = retire_count_q;

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for the writeback stage. Uses a 4-bit retire counter
// so that counter wrap is reachable in a few cycles.
module tb_writeback;
  localparam int unsigned WS = 32;
  localparam int unsigned CW = 4;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  writeback_if #(.WORD_SIZE(WS), .COUNT_WIDTH(CW)) bus ();

  writeback #(.WORD_SIZE(WS), .COUNT_WIDTH(CW)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: architectural state plus the single in-flight result.
  logic [WS-1:0] m_regs [32];
  bit            m_pending [32];
  logic [WS-1:0] m_wb_data;
  logic [4:0]    m_wb_rd;
  logic          m_wb_we;
  logic [CW-1:0] m_count;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i]    = '0;
      m_pending[i] = 1'b0;
    end
    m_wb_data = '0;
    m_wb_rd   = '0;
    m_wb_we   = 1'b0;
    m_count   = '0;
  endtask

  // One rising edge: older result retires, then the new issue and result.
  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
    end else begin
      if (m_wb_we && m_wb_rd != 0) begin
        m_regs[m_wb_rd]    = m_wb_data;
        m_pending[m_wb_rd] = 1'b0;
        m_count            = m_count + 1'b1;
      end
      if (bus.issue_valid && bus.issue_dest != 0) m_pending[bus.issue_dest] = 1'b1;
      m_wb_data = bus.data_in;
      m_wb_rd   = bus.reg_dest_in;
      m_wb_we   = bus.write_enable_in;
    end
  endtask

  function automatic logic [WS-1:0] exp_data(input logic [4:0] a);
    if (a == 0) return '0;
`ifdef WB_BYPASS_EN
    if (m_wb_we && m_wb_rd == a) return m_wb_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_haz(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef WB_BYPASS_EN
    if (m_wb_we && m_wb_rd == a) return 1'b0;
`endif
    return m_pending[a];
  endfunction

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic present(input logic [4:0] rd, input logic [WS-1:0] d, input logic we);
    bus.reg_dest_in     = rd;
    bus.data_in         = d;
    bus.write_enable_in = we;
  endtask

  task automatic test_reset();
    #12;
    bus.read_addr1 = 5'd5;
    bus.read_addr2 = 5'd31;
    #1;
    checks++;
    if (bus.read_data1 !== '0 || bus.read_data2 !== '0 || bus.hazard1 !== 1'b0 ||
        bus.hazard2 !== 1'b0 || bus.retire_count !== '0) begin
      errors++;
      $display("FAIL reset_initial: got d1=%h d2=%h h1=%b h2=%b cnt=%h expected all 0",
               bus.read_data1, bus.read_data2, bus.hazard1, bus.hazard2, bus.retire_count);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    bus.issue_valid = 1'b1;
    bus.issue_dest  = 5'd3;
    present(5'd4, 32'hCAFE0004, 1'b1);
    cycle();
    bus.issue_valid = 1'b0;
    present(5'd3, 32'h0000BEEF, 1'b1);
    cycle();
    // Reset lands while x3's write sits in the stage latch.
    #2;
    reset_n = 1'b0;
    model_reset();
    bus.read_addr1 = 5'd3;
    bus.read_addr2 = 5'd4;
    #1;
    checks++;
    if (bus.read_data1 !== '0 || bus.read_data2 !== '0 || bus.hazard1 !== 1'b0 ||
        bus.retire_count !== '0) begin
      errors++;
      $display("FAIL reset_midstream: got d1=%h d2=%h h1=%b cnt=%h expected all 0",
               bus.read_data1, bus.read_data2, bus.hazard1, bus.retire_count);
    end
    cycle();
    reset_n = 1'b1;
    present(5'd0, '0, 1'b0);
    cycle();
    cycle();
    #2;
    checks++;
    if (bus.read_data1 !== '0 || bus.read_data2 !== '0 || bus.retire_count !== '0) begin
      errors++;
      $display("FAIL reset_no_late_write: got x3=%h x4=%h cnt=%h expected 0 0 0",
               bus.read_data1, bus.read_data2, bus.retire_count);
    end
  endtask

  task automatic test_basic();
    logic [CW-1:0] cnt0;
    logic          h_exp;
    bus.issue_valid = 1'b1;
    bus.issue_dest  = 5'd5;
    bus.read_addr1  = 5'd5;
    cycle();
    bus.issue_valid = 1'b0;
    present(5'd5, 32'hDEADBEEF, 1'b1);
    #2;
    checks++;
    if (bus.hazard1 !== 1'b1) begin
      errors++;
      $display("FAIL basic_hazard_after_issue: got %b expected 1", bus.hazard1);
    end
    cnt0 = m_count;
    cycle();
    present(5'd0, '0, 1'b0);
    #2;
`ifdef WB_BYPASS_EN
    h_exp = 1'b0;
`else
    h_exp = 1'b1;
`endif
    checks++;
    if (bus.hazard1 !== h_exp || bus.read_data1 !== exp_data(5'd5)) begin
      errors++;
      $display("FAIL basic_latched: got h=%b d=%h expected h=%b d=%h",
               bus.hazard1, bus.read_data1, h_exp, exp_data(5'd5));
    end
    cycle();
    #2;
    checks++;
    if (bus.read_data1 !== 32'hDEADBEEF || bus.hazard1 !== 1'b0 ||
        bus.retire_count !== CW'(cnt0 + 1'b1)) begin
      errors++;
      $display("FAIL basic_committed: got d=%h h=%b cnt=%h expected deadbeef 0 %h",
               bus.read_data1, bus.hazard1, bus.retire_count, CW'(cnt0 + 1'b1));
    end
  endtask

  task automatic test_x0();
    logic [CW-1:0] cnt0;
    cnt0 = m_count;
    present(5'd0, 32'h00001234, 1'b1);
    bus.issue_valid = 1'b1;
    bus.issue_dest  = 5'd0;
    cycle();
    present(5'd0, '0, 1'b0);
    bus.issue_valid = 1'b0;
    bus.read_addr1  = 5'd0;
    bus.read_addr2  = 5'd0;
    cycle();
    #2;
    checks++;
    if (bus.read_data1 !== '0 || bus.read_data2 !== '0 || bus.hazard1 !== 1'b0 ||
        bus.retire_count !== cnt0) begin
      errors++;
      $display("FAIL x0_protect: got d=%h h=%b cnt=%h expected 0 0 %h",
               bus.read_data1, bus.hazard1, bus.retire_count, cnt0);
    end
  endtask

  task automatic test_same_edge();
    present(5'd7, 32'h00000011, 1'b1);
    bus.read_addr1 = 5'd7;
    cycle();
    present(5'd0, '0, 1'b0);
    bus.issue_valid = 1'b1;
    bus.issue_dest  = 5'd7;
    cycle();
    bus.issue_valid = 1'b0;
    cycle();
    cycle();
    #2;
    checks++;
    if (bus.read_data1 !== 32'h11 || bus.hazard1 !== 1'b1) begin
      errors++;
      $display("FAIL same_edge_issue_commit: got d=%h h=%b expected 00000011 1",
               bus.read_data1, bus.hazard1);
    end
    present(5'd7, 32'h00000022, 1'b1);
    cycle();
    present(5'd0, '0, 1'b0);
    cycle();
    #2;
    checks++;
    if (bus.read_data1 !== 32'h22 || bus.hazard1 !== 1'b0) begin
      errors++;
      $display("FAIL same_edge_next_commit: got d=%h h=%b expected 00000022 0",
               bus.read_data1, bus.hazard1);
    end
  endtask

  task automatic test_bypass();
    logic [WS-1:0] d_exp;
    logic          h_exp;
    present(5'd9, 32'h00000055, 1'b1);
    cycle();
    present(5'd0, '0, 1'b0);
    cycle();
    bus.issue_valid = 1'b1;
    bus.issue_dest  = 5'd9;
    cycle();
    bus.issue_valid = 1'b0;
    present(5'd9, 32'hA5A5A5A5, 1'b1);
    cycle();
    present(5'd0, '0, 1'b0);
    bus.read_addr2 = 5'd9;
    #2;
`ifdef WB_BYPASS_EN
    d_exp = 32'hA5A5A5A5;
    h_exp = 1'b0;
`else
    d_exp = 32'h00000055;
    h_exp = 1'b1;
`endif
    checks++;
    if (bus.read_data2 !== d_exp || bus.hazard2 !== h_exp) begin
      errors++;
      $display("FAIL bypass_window: got d=%h h=%b expected d=%h h=%b",
               bus.read_data2, bus.hazard2, d_exp, h_exp);
    end
    cycle();
    #2;
    checks++;
    if (bus.read_data2 !== 32'hA5A5A5A5 || bus.hazard2 !== 1'b0) begin
      errors++;
      $display("FAIL bypass_after_commit: got d=%h h=%b expected a5a5a5a5 0",
               bus.read_data2, bus.hazard2);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset_n = ($urandom_range(0, 63) != 0);
      if (!reset_n) model_reset();
      present(5'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 3) != 0));
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_dest  = 5'($urandom_range(0, 15));
      bus.read_addr1  = 5'($urandom_range(0, 15));
      bus.read_addr2  = 5'($urandom_range(0, 15));
      #2;
      checks++;
      if (bus.read_data1 !== exp_data(bus.read_addr1) || bus.hazard1 !== exp_haz(bus.read_addr1) ||
          bus.read_data2 !== exp_data(bus.read_addr2) || bus.hazard2 !== exp_haz(bus.read_addr2) ||
          bus.retire_count !== m_count) begin
        errors++;
        $display("FAIL random_%0d: got a1=%0d d1=%h h1=%b a2=%0d d2=%h h2=%b cnt=%h expected d1=%h h1=%b d2=%h h2=%b cnt=%h",
                 n, bus.read_addr1, bus.read_data1, bus.hazard1, bus.read_addr2,
                 bus.read_data2, bus.hazard2, bus.retire_count, exp_data(bus.read_addr1),
                 exp_haz(bus.read_addr1), exp_data(bus.read_addr2), exp_haz(bus.read_addr2),
                 m_count);
      end
      cycle();
    end
    reset_n = 1'b1;
  endtask

  task automatic test_wrap();
    reset_n = 1'b0;
    model_reset();
    bus.issue_valid = 1'b0;
    present(5'd0, '0, 1'b0);
    cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      present(5'((i % 30) + 1), $urandom, 1'b1);
      cycle();
    end
    present(5'd0, '0, 1'b0);
    cycle();
    #2;
    checks++;
    if (bus.retire_count !== {CW{1'b1}}) begin
      errors++;
      $display("FAIL wrap_all_ones: got %h expected %h", bus.retire_count, {CW{1'b1}});
    end
    present(5'd12, 32'h0BADF00D, 1'b1);
    cycle();
    present(5'd0, '0, 1'b0);
    cycle();
    #2;
    checks++;
    if (bus.retire_count !== '0) begin
      errors++;
      $display("FAIL wrap_to_zero: got %h expected 0", bus.retire_count);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_dest  = '0;
    bus.read_addr1  = '0;
    bus.read_addr2  = '0;
    present(5'd0, '0, 1'b0);
    model_reset();
    test_reset();
    test_basic();
    test_x0();
    test_same_edge();
    test_bypass();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
